// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO fed by UART done_rx rising edges; ports clk, rst(n), rx_data, done_rx, rd_en, ovf_clr -> dout, empty, full, count, overflow
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          done_rx,
  input  logic          rd_en,
  input  logic          ovf_clr,
  output logic [7:0]    dout,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]    mem_q [DEPTH];
  logic          done_q;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_ev, rd, wr, drop;
  always_comb begin
    empty = count_q == '0;
    full = count_q == CW'(DEPTH);
    wr_ev = done_rx & ~done_q;
    rd = rd_en & ~empty;
    wr = wr_ev & (~full | rd);
    drop = wr_ev & full & ~rd;
    wp_d = wr ? wp_q + AW'(1) : wp_q;
    rp_d = rd ? rp_q + AW'(1) : rp_q;
    count_d = count_q + CW'(wr) - CW'(rd);
    ovf_d = drop | (ovf_q & ~ovf_clr);
    dout = mem_q[rp_q];
    count = count_q;
    overflow = ovf_q;
  end
  always_ff @(posedge clk)
    if (rst && wr) mem_q[wp_q] <= rx_data;
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_q <= 1'b1;
      wp_q <= '0;
      rp_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      done_q <= done_rx;
      wp_q <= wp_d;
      rp_q <= rp_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic       clk = 0, rst = 0, done_rx = 0, rd_en = 0, ovf_clr = 0;
  logic [7:0] rx_data = 0, dout;
  logic       empty, full, overflow;
  logic [4:0] count;
  logic [7:0] q[$];
  int         errs = 0, checks = 0;
  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .done_rx(done_rx), .rd_en(rd_en),
    .ovf_clr(ovf_clr), .dout(dout), .empty(empty), .full(full), .count(count),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic cyc(int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(logic [7:0] b, int hold = 2);
    rx_data = b;
    done_rx = 1;
    if (q.size() < 16) q.push_back(b);
    cyc(hold);
    done_rx = 0;
    rx_data = 8'hEE;
    cyc(1);
  endtask
  task automatic pop(string tag);
    chk({tag, "_nonempty"}, empty, 0);
    chk(tag, dout, q.pop_front());
    rd_en = 1;
    cyc(1);
    rd_en = 0;
  endtask
  initial begin
    cyc(3);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1;
    cyc(1);
    push(8'hA5, 40);
    chk("long_count", count, 1);
    chk("long_dout", dout, 8'hA5);
    pop("long_pop");
    chk("long_empty", empty, 1);
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    for (int i = 0; i < 16; i++) pop("seq_dout");
    chk("drain_empty", empty, 1);
    chk("drain_full", full, 0);
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
    push(8'hFF, 3);
    chk("drop_ovf", overflow, 1);
    chk("drop_count", count, 16);
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    chk("ovf_clr", overflow, 0);
    rx_data = 8'hFE;
    done_rx = 1;
    cyc(1);
    chk("drop2_ovf", overflow, 1);
    done_rx = 0;
    cyc(1);
    rx_data = 8'hFD;
    done_rx = 1;
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    done_rx = 0;
    chk("set_wins", overflow, 1);
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    chk("ovf_clr2", overflow, 0);
    chk("fw_head", dout, q.pop_front());
    q.push_back(8'h55);
    rx_data = 8'h55;
    done_rx = 1;
    rd_en = 1;
    cyc(1);
    rd_en = 0;
    cyc(1);
    done_rx = 0;
    chk("fullrw_count", count, 16);
    chk("fullrw_ovf", overflow, 0);
    for (int i = 0; i < 15; i++) pop("fullrw_dout");
    chk("fullrw_last", dout, 8'h55);
    pop("fullrw_pop16");
    chk("fullrw_empty", empty, 1);
    rx_data = 8'h3C;
    done_rx = 1;
    rd_en = 1;
    q.push_back(8'h3C);
    cyc(1);
    rd_en = 0;
    done_rx = 0;
    chk("emptyrw_count", count, 1);
    chk("emptyrw_dout", dout, 8'h3C);
    pop("emptyrw_pop");
    rd_en = 1;
    cyc(2);
    rd_en = 0;
    chk("rd_empty_count", count, 0);
    chk("rd_empty_empty", empty, 1);
    done_rx = 1;
    rst = 0;
    cyc(2);
    rst = 1;
    cyc(3);
    chk("no_spurious", count, 0);
    done_rx = 0;
    cyc(1);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    chk("mid_count", count, 3);
    rx_data = 8'h04;
    done_rx = 1;
    rd_en = 1;
    rst = 0;
    cyc(1);
    rst = 1;
    rd_en = 0;
    done_rx = 0;
    q.delete();
    cyc(1);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_ovf", overflow, 0);
    push(8'h77);
    chk("post_rst_count", count, 1);
    pop("post_rst_dout");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
